// File: rtl/decode_stage.sv
// decode_stage: one-entry instruction decode register for the MIPS-subset
// pipeline. It splits the fetched word into fields and control bits, holds
// the result for execute, and stalls readers of registers whose writeback is
// still outstanding, tracked in a 32-entry pending-write scoreboard.
module decode_stage #(
    parameter int INSTR_W   = 32,
    parameter bit SB_ENABLE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inValid,
    output logic               inReady,
    input  logic [INSTR_W-1:0] instr,
    input  logic [31:0]        pcIn,
    input  logic               flush,
    output logic               outValid,
    input  logic               outReady,
    output logic [31:0]        pcOut,
    output logic [4:0]         readReg1,
    output logic [4:0]         readReg2,
    output logic [4:0]         writeReg,
    output logic [31:0]        imm,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic [4:0]         shamt,
    output logic               regWrite,
    output logic               memRead,
    output logic               memWrite,
    output logic               branch,
    output logic               jump,
    output logic               illegal,
    input  logic               wbValid,
    input  logic [4:0]         wbReg
);

    // Raw instruction fields
    logic [5:0]  op_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [15:0] imm16_s;

    assign op_s    = instr[31:26];
    assign rs_s    = instr[25:21];
    assign rt_s    = instr[20:16];
    assign rd_s    = instr[15:11];
    assign imm16_s = instr[15:0];

    // Decoded controls for the incoming instruction
    logic        use_rs_s;
    logic        use_rt_s;
    logic [4:0]  wr_s;
    logic [31:0] imm_s;
    logic        reg_write_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        branch_s;
    logic        jump_s;
    logic        illegal_s;

    // Held (output register) state
    logic        out_valid_r;
    logic [31:0] pc_r;
    logic [4:0]  read_reg1_r;
    logic [4:0]  read_reg2_r;
    logic [4:0]  write_reg_r;
    logic [31:0] imm_r;
    logic [5:0]  opcode_r;
    logic [5:0]  funct_r;
    logic [4:0]  shamt_r;
    logic        reg_write_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic        branch_r;
    logic        jump_r;
    logic        illegal_r;

    // Scoreboard
    logic [31:0] pending_r;
    logic [31:0] pending_nxt_s;
    logic [31:0] set_vec_s;
    logic [31:0] clr_vec_s;

    // Handshake and hazard terms
    logic rs_busy_s;
    logic rt_busy_s;
    logic hazard_s;
    logic in_ready_s;
    logic load_s;
    logic handoff_s;

    // Opcode decode into source usage, destination, immediate and controls
    always_comb begin
        use_rs_s    = 1'b0;
        use_rt_s    = 1'b0;
        wr_s        = 5'd0;
        imm_s       = {{16{imm16_s[15]}}, imm16_s};
        reg_write_s = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        branch_s    = 1'b0;
        jump_s      = 1'b0;
        illegal_s   = 1'b0;
        case (op_s)
            6'h00: begin
                use_rs_s = 1'b1;
                use_rt_s = 1'b1;
                wr_s     = rd_s;
                if (instr[5:0] == 6'h08) begin
                    jump_s = 1'b1;
                end else begin
                    reg_write_s = 1'b1;
                end
            end
            6'h08, 6'h09, 6'h0A: begin
                use_rs_s    = 1'b1;
                wr_s        = rt_s;
                reg_write_s = 1'b1;
            end
            6'h0C, 6'h0D: begin
                use_rs_s    = 1'b1;
                wr_s        = rt_s;
                reg_write_s = 1'b1;
                imm_s       = {16'h0000, imm16_s};
            end
            6'h0F: begin
                wr_s        = rt_s;
                reg_write_s = 1'b1;
                imm_s       = {imm16_s, 16'h0000};
            end
            6'h23: begin
                use_rs_s    = 1'b1;
                wr_s        = rt_s;
                reg_write_s = 1'b1;
                mem_read_s  = 1'b1;
            end
            6'h2B: begin
                use_rs_s    = 1'b1;
                use_rt_s    = 1'b1;
                mem_write_s = 1'b1;
            end
            6'h04, 6'h05: begin
                use_rs_s = 1'b1;
                use_rt_s = 1'b1;
                branch_s = 1'b1;
            end
            6'h02: begin
                jump_s = 1'b1;
                imm_s  = {6'b000000, instr[25:0]};
            end
            6'h03: begin
                jump_s      = 1'b1;
                wr_s        = 5'd31;
                reg_write_s = 1'b1;
                imm_s       = {6'b000000, instr[25:0]};
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Hazard detection against the scoreboard and the held producer (no bypass)
    always_comb begin
        rs_busy_s = use_rs_s && (rs_s != 5'd0) &&
                    (pending_r[rs_s] || (out_valid_r && reg_write_r && (write_reg_r == rs_s)));
        rt_busy_s = use_rt_s && (rt_s != 5'd0) &&
                    (pending_r[rt_s] || (out_valid_r && reg_write_r && (write_reg_r == rt_s)));
        if (SB_ENABLE) begin
            hazard_s = rs_busy_s || rt_busy_s;
        end else begin
            hazard_s = 1'b0;
        end
        in_ready_s = (!out_valid_r || outReady) && !hazard_s && !flush;
        load_s     = inValid && in_ready_s;
        handoff_s  = out_valid_r && outReady;
    end

    // Scoreboard next state: a handed-off writer sets its bit (winning over a
    // same-cycle clear), a flushed instruction sets nothing, r0 never pends
    always_comb begin
        set_vec_s = 32'd0;
        clr_vec_s = 32'd0;
        if (handoff_s && !flush && reg_write_r) begin
            set_vec_s = 32'd1 << write_reg_r;
        end else begin
            set_vec_s = 32'd0;
        end
        if (wbValid) begin
            clr_vec_s = 32'd1 << wbReg;
        end else begin
            clr_vec_s = 32'd0;
        end
        pending_nxt_s = ((pending_r & ~clr_vec_s) | set_vec_s) & 32'hFFFF_FFFE;
    end

    // Pending-write scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Output register: load on accept, drop on handoff or flush, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            pc_r        <= 32'd0;
            read_reg1_r <= 5'd0;
            read_reg2_r <= 5'd0;
            write_reg_r <= 5'd0;
            imm_r       <= 32'd0;
            opcode_r    <= 6'd0;
            funct_r     <= 6'd0;
            shamt_r     <= 5'd0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            branch_r    <= 1'b0;
            jump_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            pc_r        <= pcIn;
            read_reg1_r <= rs_s;
            read_reg2_r <= rt_s;
            write_reg_r <= wr_s;
            imm_r       <= imm_s;
            opcode_r    <= op_s;
            funct_r     <= instr[5:0];
            shamt_r     <= instr[10:6];
            reg_write_r <= reg_write_s && (wr_s != 5'd0);
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            branch_r    <= branch_s;
            jump_r      <= jump_s;
            illegal_r   <= illegal_s;
        end else if (flush || handoff_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign inReady  = in_ready_s;
    assign outValid = out_valid_r;
    assign pcOut    = pc_r;
    assign readReg1 = read_reg1_r;
    assign readReg2 = read_reg2_r;
    assign writeReg = write_reg_r;
    assign imm      = imm_r;
    assign opcode   = opcode_r;
    assign funct    = funct_r;
    assign shamt    = shamt_r;
    assign regWrite = reg_write_r;
    assign memRead  = mem_read_r;
    assign memWrite = mem_write_r;
    assign branch   = branch_r;
    assign jump     = jump_r;
    assign illegal  = illegal_r;

endmodule
